// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out MSB- or LSB-first, one bit per unpaused cycle.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    input  logic             shift_pause,
    output logic             shift_out,
    output logic             shift_en,
    output logic             frame_done,
    output logic             busy,
    output logic             state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] data_q, data_next;
    logic             dir_q, dir_next;
    logic             last_bit;
    logic             accept;
    logic [CW-1:0]    msb_idx;

    // Handshake: a word transfers on any rising edge where load_valid && load_ready.
    // load_ready never depends on load_valid; the producer holds the word until taken.
    always_comb begin
        state_next = state;
        count_next = count;
        data_next  = data_q;
        dir_next   = dir_q;
        last_bit   = (state == SHIFT) && (count == LAST) && !shift_pause;
        load_ready = (state == IDLE) || last_bit;
        accept     = load_valid && load_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    count_next = '0;
                    data_next  = load_data;
                    dir_next   = load_dir;
                end
            end
            SHIFT: begin
                if (!shift_pause) begin
                    if (count == LAST) begin
                        count_next = '0;
                        // Loading in the last-bit cycle keeps shift_en contiguous across words.
                        if (accept) begin
                            data_next = load_data;
                            dir_next  = load_dir;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            data_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            data_q <= data_next;
            dir_q  <= dir_next;
        end
    end

    // shift_out is selected only from registered state, never from load_*.
    always_comb begin
        msb_idx    = LAST - count;
        busy       = (state == SHIFT);
        shift_en   = (state == SHIFT) && !shift_pause;
        frame_done = last_bit;
        state_dbg  = state;
        shift_out  = 1'b0;
        if (state == SHIFT) begin
            shift_out = dir_q ? data_q[msb_idx] : data_q[count];
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer: per-scenario tasks with inline checks
// against hand-computed bit sequences and a receiver shift-register model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       load_dir;
    logic       shift_pause;
    logic       shift_out;
    logic       shift_en;
    logic       frame_done;
    logic       busy;
    logic       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rx;

    piso_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dir   (load_dir),
        .shift_pause(shift_pause),
        .shift_out  (shift_out),
        .shift_en   (shift_en),
        .frame_done (frame_done),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Receiver model: shift_left=1 shifts toward MSB, shift_left=0 toward LSB.
    task automatic rx_shift(input logic left, input logic b);
        if (left) rx = {rx[6:0], b};
        else      rx = {b, rx[7:1]};
    endtask

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; load_data = 8'h00; load_dir = 1'b0; shift_pause = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (shift_out !== 1'b0) begin n_fail++; $display("FAIL reset_shift_out got=%b exp=0", shift_out); end
        n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL reset_shift_en got=%b exp=0", shift_en); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
        n_checks++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_state got=%b exp=0", state_dbg); end
        reset = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        seq = 8'b1010_0101;
        rx = 8'h00;
        @(negedge clk); load_valid = 1'b1; load_data = 8'hA5; load_dir = 1'b1; #1;
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL msb_idle_ready got=%b exp=1", load_ready); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); load_valid = 1'b0; load_data = 8'h00; load_dir = 1'b0; #1;
            n_checks++; if (shift_en !== 1'b1) begin n_fail++; $display("FAIL msb_en k=%0d got=%b exp=1", k, shift_en); end
            n_checks++; if (shift_out !== seq[7-k]) begin n_fail++; $display("FAIL msb_bit k=%0d got=%b exp=%b", k, shift_out, seq[7-k]); end
            n_checks++; if (frame_done !== (k == 7)) begin n_fail++; $display("FAIL msb_done k=%0d got=%b exp=%b", k, frame_done, (k == 7)); end
            n_checks++; if (load_ready !== (k == 7)) begin n_fail++; $display("FAIL msb_ready k=%0d got=%b exp=%b", k, load_ready, (k == 7)); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL msb_busy k=%0d got=%b exp=1", k, busy); end
            if (shift_en) rx_shift(1'b1, shift_out);
        end
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL msb_end_busy got=%b exp=0", busy); end
        n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL msb_end_en got=%b exp=0", shift_en); end
        n_checks++; if (rx !== 8'hA5) begin n_fail++; $display("FAIL msb_rx got=%h exp=a5", rx); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        seq = 8'b1000_0000;
        rx = 8'h00;
        @(negedge clk); load_valid = 1'b1; load_data = 8'h01; load_dir = 1'b0; #1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); load_valid = 1'b0; load_data = 8'hFF; load_dir = 1'b1; #1;
            n_checks++; if (shift_en !== 1'b1) begin n_fail++; $display("FAIL lsb_en k=%0d got=%b exp=1", k, shift_en); end
            n_checks++; if (shift_out !== seq[7-k]) begin n_fail++; $display("FAIL lsb_bit k=%0d got=%b exp=%b", k, shift_out, seq[7-k]); end
            n_checks++; if (frame_done !== (k == 7)) begin n_fail++; $display("FAIL lsb_done k=%0d got=%b exp=%b", k, frame_done, (k == 7)); end
            if (shift_en) rx_shift(1'b0, shift_out);
        end
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lsb_end_busy got=%b exp=0", busy); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL lsb_end_ready got=%b exp=1", load_ready); end
        n_checks++; if (rx !== 8'h01) begin n_fail++; $display("FAIL lsb_rx got=%h exp=01", rx); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq;
        seq = 16'b1010_0101_0011_1100;
        rx = 8'h00;
        @(negedge clk); load_valid = 1'b1; load_data = 8'hA5; load_dir = 1'b1; #1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            load_valid = (k < 8); load_data = 8'h3C; load_dir = 1'b0;
            #1;
            n_checks++; if (shift_en !== 1'b1) begin n_fail++; $display("FAIL b2b_en k=%0d got=%b exp=1", k, shift_en); end
            n_checks++; if (shift_out !== seq[15-k]) begin n_fail++; $display("FAIL b2b_bit k=%0d got=%b exp=%b", k, shift_out, seq[15-k]); end
            n_checks++; if (frame_done !== (k == 7 || k == 15)) begin n_fail++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, frame_done, (k == 7 || k == 15)); end
            n_checks++; if (load_ready !== (k == 7 || k == 15)) begin n_fail++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, load_ready, (k == 7 || k == 15)); end
            if (shift_en) rx_shift(k < 8, shift_out);
            if (k == 7) begin
                n_checks++; if (rx !== 8'hA5) begin n_fail++; $display("FAIL b2b_rx0 got=%h exp=a5", rx); end
                rx = 8'h00;
            end
        end
        @(negedge clk); load_valid = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
        n_checks++; if (rx !== 8'h3C) begin n_fail++; $display("FAIL b2b_rx1 got=%h exp=3c", rx); end
    endtask

    task automatic test_pause_mid();
        logic [7:0] seq;
        int idx;
        seq = 8'b1111_0000;
        rx = 8'h00;
        @(negedge clk); load_valid = 1'b1; load_data = 8'hF0; load_dir = 1'b1; #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); load_valid = 1'b0; shift_pause = (c == 3 || c == 4); #1;
            idx = (c < 3) ? c : ((c <= 5) ? 3 : c - 2);
            n_checks++; if (shift_en !== !(c == 3 || c == 4)) begin n_fail++; $display("FAIL pause_en c=%0d got=%b exp=%b", c, shift_en, !(c == 3 || c == 4)); end
            n_checks++; if (shift_out !== seq[7-idx]) begin n_fail++; $display("FAIL pause_bit c=%0d got=%b exp=%b", c, shift_out, seq[7-idx]); end
            n_checks++; if (frame_done !== (c == 9)) begin n_fail++; $display("FAIL pause_done c=%0d got=%b exp=%b", c, frame_done, (c == 9)); end
            if (shift_en) rx_shift(1'b1, shift_out);
        end
        @(negedge clk); shift_pause = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pause_end_busy got=%b exp=0", busy); end
        n_checks++; if (rx !== 8'hF0) begin n_fail++; $display("FAIL pause_rx got=%h exp=f0", rx); end
    endtask

    task automatic test_pause_last();
        logic [7:0] seq;
        int idx;
        seq = 8'b1000_0001;
        @(negedge clk); load_valid = 1'b1; load_data = 8'h81; load_dir = 1'b1; #1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); shift_pause = (c == 7); load_valid = (c == 7); load_data = 8'h55; #1;
            idx = (c <= 7) ? c : 7;
            n_checks++; if (shift_out !== seq[7-idx]) begin n_fail++; $display("FAIL plast_bit c=%0d got=%b exp=%b", c, shift_out, seq[7-idx]); end
            n_checks++; if (frame_done !== (c == 8)) begin n_fail++; $display("FAIL plast_done c=%0d got=%b exp=%b", c, frame_done, (c == 8)); end
            n_checks++; if (load_ready !== (c == 8)) begin n_fail++; $display("FAIL plast_ready c=%0d got=%b exp=%b", c, load_ready, (c == 8)); end
        end
        @(negedge clk); shift_pause = 1'b0; load_valid = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL plast_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq;
        seq = 8'b1000_0001;
        @(negedge clk); load_valid = 1'b1; load_data = 8'hFF; load_dir = 1'b1; #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); load_valid = 1'b0; reset = (c == 4); #1;
            n_checks++; if (shift_out !== 1'b1 || shift_en !== 1'b1) begin n_fail++; $display("FAIL rmid_bit c=%0d got=%b/%b exp=1/1", c, shift_out, shift_en); end
        end
        @(negedge clk); reset = 1'b0; #1;
        n_checks++; if (shift_out !== 1'b0) begin n_fail++; $display("FAIL rmid_shift_out got=%b exp=0", shift_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%b exp=1", load_ready); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got=%b exp=0", frame_done); end
        rx = 8'h00;
        load_valid = 1'b1; load_data = 8'h81; load_dir = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); load_valid = 1'b0; #1;
            n_checks++; if (shift_out !== seq[7-k]) begin n_fail++; $display("FAIL rmid_bit2 k=%0d got=%b exp=%b", k, shift_out, seq[7-k]); end
            if (shift_en) rx_shift(1'b1, shift_out);
        end
        @(negedge clk); #1;
        n_checks++; if (rx !== 8'h81) begin n_fail++; $display("FAIL rmid_rx got=%h exp=81", rx); end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] seq;
        seq = 8'b1100_0011;
        rx = 8'h00;
        @(negedge clk); shift_pause = 1'b1; load_valid = 1'b1; load_data = 8'hC3; load_dir = 1'b1; #1;
        n_checks++; if (load_ready !== 1'b1 || shift_en !== 1'b0) begin n_fail++; $display("FAIL idle_pause got=%b/%b exp=1/0", load_ready, shift_en); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); shift_pause = 1'b0; load_valid = (c % 2 == 0); load_data = 8'h55; load_dir = 1'b0; #1;
            n_checks++; if (load_ready !== (c == 7)) begin n_fail++; $display("FAIL ign_ready c=%0d got=%b exp=%b", c, load_ready, (c == 7)); end
            n_checks++; if (shift_out !== seq[7-c]) begin n_fail++; $display("FAIL ign_bit c=%0d got=%b exp=%b", c, shift_out, seq[7-c]); end
            if (shift_en) rx_shift(1'b1, shift_out);
        end
        @(negedge clk); load_valid = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_end_busy got=%b exp=0", busy); end
        n_checks++; if (rx !== 8'hC3) begin n_fail++; $display("FAIL ign_rx got=%h exp=c3", rx); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_pause_mid();
        test_pause_last();
        test_reset_mid();
        test_busy_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
